// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer:
// opcodes, FSM states and the queued command word.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       use_acc;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: push/pop, occupancy count, full/empty.
// Ports: push_i/push_data_i, pop_i/pop_data_o (head), count_o, full_o, empty_o.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Full blocks push even if a pop happens this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are AW bits wide, so they wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them on registered ALU ports, and returns
// captured result/carry/zero/opcode over a valid/ready response channel.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_sel,
  input  logic [7:0]                 cmd_a,
  input  logic [7:0]                 cmd_b,
  input  logic                       cmd_cin,
  input  logic                       cmd_use_acc,
  input  logic                       clear_acc,
  output logic [2:0]                 alu_sel,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic                       alu_cin,
  input  logic [15:0]                alu_result,
  input  logic                       alu_carry,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [15:0]                rsp_result,
  output logic                       rsp_carry,
  output logic                       rsp_zero,
  output logic [2:0]                 rsp_sel,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [7:0]                 acc
);

  cmd_t   push_cmd, head;
  logic   full, empty, fifo_pop, load;
  state_e state_q, state_d;

  logic [2:0]  alu_sel_q, alu_sel_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic        alu_cin_q, alu_cin_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic [2:0]  rsp_sel_q, rsp_sel_d;
  logic [7:0]  acc_q, acc_d;

  assign push_cmd = '{sel: cmd_sel, a: cmd_a, b: cmd_b,
                      cin: cmd_cin, use_acc: cmd_use_acc};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cmd_valid),
    .push_data_i (push_cmd),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .count_o     (fifo_count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign cmd_ready  = ~full;
  assign alu_sel    = alu_sel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_sel    = rsp_sel_q;
  assign acc        = acc_q;

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    alu_sel_d    = alu_sel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_sel_d    = rsp_sel_q;
    acc_d        = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carry;
        rsp_zero_d   = (alu_result == 16'h0000);
        rsp_sel_d    = alu_sel_q;
        acc_d        = alu_result[7:0];
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) begin
            load    = 1'b1;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // acc here is already the previous command's capture.
    if (load) begin
      alu_sel_d = head.sel;
      alu_a_d   = head.use_acc ? acc_q : head.a;
      alu_b_d   = head.b;
      alu_cin_d = head.cin;
    end
    if (clear_acc) acc_d = 8'h00;
  end

  assign fifo_pop = load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_sel_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_sel_q    <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_sel_q    <= alu_sel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_sel_q    <= rsp_sel_d;
      acc_q        <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 8-bit ALU.
// Directed commands push expected responses; a monitor checks them.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_sel;
  logic [7:0]  cmd_a, cmd_b;
  logic        cmd_cin, cmd_use_acc, clear_acc;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_a, alu_b;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_zero;
  logic [2:0]  rsp_sel;
  logic [2:0]  fifo_count;
  logic [7:0]  acc;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic [2:0]  sel;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_cin(cmd_cin), .cmd_use_acc(cmd_use_acc),
    .clear_acc(clear_acc),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_sel(rsp_sel),
    .fifo_count(fifo_count), .acc(acc)
  );

  // Behavioural alu_8bit: sub carry means no borrow.
  always_comb begin
    alu_result = 16'h0000;
    alu_carry  = 1'b0;
    case (alu_sel)
      OP_ADD: {alu_carry, alu_result[7:0]} =
                9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
      OP_SUB: begin
        alu_result[7:0] = alu_a - alu_b;
        alu_carry       = (alu_a >= alu_b);
      end
      OP_MUL: alu_result = 16'(alu_a) * 16'(alu_b);
      OP_AND: alu_result[7:0] = alu_a & alu_b;
      OP_OR:  alu_result[7:0] = alu_a | alu_b;
      OP_XOR: alu_result[7:0] = alu_a ^ alu_b;
      OP_NOT: alu_result[7:0] = ~alu_a;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got %0h expected none",
                 rsp_result);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        chk("rsp_carry", 32'(rsp_carry), 32'(mon_e.c));
        chk("rsp_zero", 32'(rsp_zero), 32'(mon_e.z));
        chk("rsp_sel", 32'(rsp_sel), 32'(mon_e.sel));
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(logic [2:0] s, logic [7:0] a, logic [7:0] b,
                       logic ci, logic ua);
    cmd_valid   = 1'b1;
    cmd_sel     = s;
    cmd_a       = a;
    cmd_b       = b;
    cmd_cin     = ci;
    cmd_use_acc = ua;
  endtask

  task automatic send(logic [2:0] s, logic [7:0] a, logic [7:0] b,
                      logic ci, logic ua,
                      logic [15:0] r, logic c, logic z);
    drive(s, a, b, ci, ua);
    chk("send_cmd_ready", 32'(cmd_ready), 32'd1);
    sb.push_back('{res: r, c: c, z: z, sel: s});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_alu"}, 32'({alu_sel, alu_a, alu_b, alu_cin}), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_result, rsp_carry, rsp_zero, rsp_sel}),
        32'd0);
    chk({tag, "_acc"}, 32'(acc), 32'd0);
  endtask

  logic [2:0]  cap_s [6] = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SUB, OP_ADD};
  logic [7:0]  cap_a [6] = '{8'hF0, 8'hF0, 8'hFF, 8'h5A, 8'h03, 8'h01};
  logic [7:0]  cap_b [6] = '{8'h3C, 8'h0F, 8'h0F, 8'h00, 8'h05, 8'h01};
  logic [15:0] cap_r [6] = '{16'h0030, 16'h00FF, 16'h00F0, 16'h00A5,
                             16'h00FE, 16'h0002};

  initial begin
    cmd_valid   = 1'b0;
    cmd_sel     = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_cin     = 1'b0;
    cmd_use_acc = 1'b0;
    clear_acc   = 1'b0;
    rsp_ready   = 1'b1;
    #2;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accept at E0, alu_* after E1, rsp_valid after E2.
    drive(OP_ADD, 8'h0F, 8'h01, 1'b0, 1'b0);
    sb.push_back('{res: 16'h0010, c: 1'b0, z: 1'b0, sel: OP_ADD});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_e1_alu", 32'({alu_sel, alu_a, alu_b}),
        32'({OP_ADD, 8'h0F, 8'h01}));
    chk("lat_e1_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_e2_valid", 32'(rsp_valid), 32'd1);
    drain(20);

    send(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    send(OP_SUB, 8'h05, 8'h05, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    drain(20);

    // Accumulator chaining: a=55 is ignored in favour of acc=78.
    send(OP_MUL, 8'h0C, 8'h0A, 1'b0, 1'b0, 16'h0078, 1'b0, 1'b0);
    send(OP_ADD, 8'h55, 8'h02, 1'b0, 1'b1, 16'h007A, 1'b0, 1'b0);
    drain(20);
    chk("acc_chain", 32'(acc), 32'h7A);

    // Clear in the EXEC cycle beats the capture.
    send(OP_ADD, 8'h03, 8'h04, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    clear_acc = 1'b1;
    @(posedge clk);
    #1;
    clear_acc = 1'b0;
    chk("acc_clear", 32'(acc), 32'd0);
    drain(20);
    chk("acc_clear_hold", 32'(acc), 32'd0);

    send(OP_RSV, 8'hAA, 8'h33, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drain(20);

    // Capacity: one in flight plus four queued, sixth refused.
    rsp_ready = 1'b0;
    hs_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      drive(cap_s[i], cap_a[i], cap_b[i], 1'b0, 1'b0);
      chk("cap_cmd_ready", 32'(cmd_ready), (i < 5) ? 32'd1 : 32'd0);
      if (i < 5)
        sb.push_back('{res: cap_r[i], c: (cap_s[i] == OP_ADD),
                       z: 1'b0, sel: cap_s[i]});
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("cap_count", 32'(fifo_count), 32'd4);
    chk("cap_full_ready", 32'(cmd_ready), 32'd0);
    chk("cap_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    drain(40);
    chk("cap_nrsp", 32'(hs_cyc.size()), 32'd5);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("cap_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

    // Reset in RESP with three queued.
    rsp_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    send(OP_ADD, 8'h04, 8'h05, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0);
    send(OP_OR,  8'h10, 8'h01, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b0);
    send(OP_AND, 8'hFF, 8'h0F, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    send(OP_ADD, 8'h20, 8'h22, 1'b1, 1'b0, 16'h0043, 1'b0, 1'b0);
    drain(20);
    chk("post_rst_acc", 32'(acc), 32'h43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Registered command front end for the combinational 8-bit ALU (`alu_8bit`). It buffers operation commands in a small FIFO and issues them one at a time on registered ALU input ports. It captures the ALU's 16-bit result and carry, and returns them with status flags over a valid/ready response channel. An 8-bit accumulator lets a command substitute the previous result's low byte for operand A, so chained operations run without a host round trip.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept (`fifo_count < DEPTH`).
- `cmd_sel`  in  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 and, 100 or, 101 xor, 110 not, 111 reserved.
- `cmd_a`, `cmd_b`  in  8 each  operands.
- `cmd_cin`  in  1  carry-in, used by add only.
- `cmd_use_acc`  in  1  replace `cmd_a` with `acc` at issue time.
- `clear_acc`  in  1  synchronous accumulator clear.
- `alu_sel`  out  3  to ALU `sel`, registered.
- `alu_a`, `alu_b`  out  8 each  to ALU, registered.
- `alu_cin`  out  1  to ALU, registered.
- `alu_result`  in  16  from ALU, combinational.
- `alu_carry`  in  1  from ALU.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  16  captured result.
- `rsp_carry`  out  1  captured carry.
- `rsp_zero`  out  1  captured result == 16'h0000.
- `rsp_sel`  out  3  opcode of this response.
- `fifo_count`  out  $clog2(DEPTH+1)  occupancy.
- `acc`  out  8  accumulator.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head, load the `alu_*` registers, and go to EXEC.
- **EXEC:** exactly one cycle. At its closing edge:
  - capture `alu_result`/`alu_carry` into the `rsp_*` registers;
  - compute `rsp_zero`;
  - set `acc <= alu_result[7:0]`;
  - set `rsp_valid=1`;
  - go to RESP.
- **RESP:** hold all `rsp_*` stable until `rsp_ready`. On the handshake edge:
  - if the FIFO is non-empty, pop and load the `alu_*` registers, then go to EXEC;
  - otherwise drop `rsp_valid` and go to IDLE.
- **Push:** occurs on `cmd_valid & cmd_ready`. `cmd_ready` depends on occupancy only. A pop in the same cycle does not free space for a push when full.
- **Simultaneous push and pop:** allowed when not full; count unchanged.
- **Pointers:** wrap modulo DEPTH.
- **Operand A source:** resolved at pop, A = `cmd_use_acc ? acc : cmd_a`. `acc` always reflects the preceding command's capture.
- **Accumulator clear:** `clear_acc` clears `acc` next edge and has priority over an EXEC capture in the same cycle.
- **Opcode 111:** issued normally; ALU returns 0, so `rsp_zero=1` and `rsp_carry=0`.
- **Register holding:** `alu_*` registers hold their last value when not loading.
- **Reset:** mid-operation reset discards FIFO contents and any in-flight response.

## Timing
- **Reset values:**
  - `cmd_ready=1`, `fifo_count=0`;
  - `alu_sel/a/b/cin=0`;
  - `rsp_valid=0`, `rsp_result=0`, `rsp_carry=0`, `rsp_zero=0`, `rsp_sel=0`;
  - `acc=0`, FSM in IDLE.
- **Latency:** command accepted at edge E0, `alu_*` driven after E1, `rsp_valid` high after E2.
- **Throughput:** with `rsp_ready` held high and the FIFO fed, one response every 2 cycles.
- **Response stability:** `rsp_*` change only on the EXEC closing edge or reset.
- **Capacity:** with `rsp_ready` low, DEPTH+1 commands are accepted before stall: one in flight plus DEPTH queued.

## Structure
- Shared package `alu_seq_pkg` holds:
  - opcode constants `OP_ADD`…`OP_NOT`;
  - FSM state enum;
  - packed command struct {sel, a, b, cin, use_acc}, 21 bits.
- Sub-module `alu_cmd_fifo`:
  - parameterised by DEPTH and payload width;
  - push/pop, count, full/empty;
  - async active-low reset.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- ADD a=8'h0F, b=8'h01, cin=0 → `rsp_result`=16'h0010, `rsp_carry`=0, `rsp_zero`=0, `rsp_valid` 2 cycles after accept.
- ADD a=8'hFF, b=8'h01, cin=0 → `rsp_result`=16'h0000, `rsp_carry`=1, `rsp_zero`=1; then SUB 5−5 → 16'h0000, `rsp_carry`=1, `rsp_zero`=1.
- MUL 12×10 → 16'h0078; then ADD `use_acc`=1, b=8'h02 → 16'h007A, `acc`=8'h7A; `clear_acc` in the EXEC cycle of a following command → `acc`=0.
- DEPTH=4, `rsp_ready` low, push 6 back-to-back → 5 accepted, `cmd_ready` low, `fifo_count`=4. Release `rsp_ready` → 5 responses in order, 2 cycles apart.
- Opcode 111 with a=8'hAA → `rsp_result`=0, `rsp_zero`=1, `rsp_sel`=3'b111.
- Assert `rst_n` low during RESP with 3 queued → all outputs at reset values immediately. After release, a new command completes normally.
